step_ramp_gen: RTL and testbench
================================

Name: step_ramp_gen

Overview:
- Upstream motion-profile stage for the half-step phase sequencer.
- Converts a move command (step count and direction) into a train of one-cycle step pulses with a trapezoidal speed profile: linear period ramp down (accelerate), cruise, then ramp up (decelerate).
- step_pulse drives the sequencer's advance/enable; dir selects the sequence direction.
- Provides a start/busy/done handshake, a controlled halt and an emergency stop.

Parameters:
- CNT_W, 16: width of the period timer and period register.
- STEPS_W, 16: width of the step count and remaining-step counter.
- MAX_PERIOD, 1000: start/stop step interval in clk cycles; requires MAX_PERIOD >= MIN_PERIOD.
- MIN_PERIOD, 100: cruise step interval in clk cycles; must be >= 2.
- ACCEL_DEC, 10: period change per step during a ramp; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-low.
- start  input  1  move request, sampled only in IDLE.
- dir_in  input  1  requested direction, latched on an accepted start.
- num_steps  input  STEPS_W  requested step count, latched on an accepted start.
- halt  input  1  controlled-stop request (level, sampled every cycle).
- estop  input  1  immediate abort (level, sampled every cycle).
- step_pulse  output  1  one-cycle step strobe to the sequencer.
- dir  output  1  latched direction.
- busy  output  1  high while a move is in progress.
- done  output  1  one-cycle pulse on normal move completion.
- aborted  output  1  one-cycle pulse when estop ends a move.
- steps_left  output  STEPS_W  remaining steps.

Behaviour:
- Reset: all outputs 0. State IDLE; timer, period and ramp_cnt cleared.
- States: IDLE, ACCEL, CRUISE, DECEL. busy = (state != IDLE).
- Start acceptance: start=1 in IDLE with num_steps != 0:
  - latch dir and remaining = num_steps; period = MAX_PERIOD; timer = 0; ramp_cnt = 0; go to ACCEL.
  - start while busy is ignored.
  - start with num_steps = 0: done pulses the next cycle, no steps are issued, state stays IDLE.
- Step timing: timer increments every cycle while busy.
  - When timer == period-1, the next cycle has step_pulse = 1 and timer resets.
  - The first pulse occurs exactly MAX_PERIOD cycles after the accepting edge.
  - Pulse spacing equals the period in effect for that interval.
- On each issued step: remaining' = remaining-1, then:
  - remaining' == 0: go to IDLE; done = 1 in the same cycle as the final step_pulse's following cycle; period and ramp_cnt cleared.
  - ACCEL: ramp_cnt' = ramp_cnt+1. If remaining' <= ramp_cnt', go to DECEL with period = min(period+ACCEL_DEC, MAX_PERIOD). Else period = max(period-ACCEL_DEC, MIN_PERIOD), and go to CRUISE when that result equals MIN_PERIOD.
  - CRUISE: if remaining' <= ramp_cnt, go to DECEL with period = min(period+ACCEL_DEC, MAX_PERIOD); otherwise unchanged.
  - DECEL: period = min(period+ACCEL_DEC, MAX_PERIOD); ramp_cnt decrements, saturating at 0.
- All period arithmetic saturates; no wrap-around.
- halt in ACCEL/CRUISE: the same cycle sets remaining = min(remaining, max(ramp_cnt,1)) and state = DECEL. Timer and period are untouched, so the interval in progress completes. halt in DECEL or IDLE has no effect.
- estop (priority over halt and step events): in any busy state, the next edge goes to IDLE. No further step_pulse, even if the timer expires that cycle. aborted pulses; done does not. estop in IDLE is ignored. start is not accepted in a cycle where estop = 1.
- dir is constant for the whole move; it changes only on an accepted start.
- Reset mid-move: immediate return to reset values; no done or aborted.

Optional Feature:
- Macro JOG_MODE_EN.
- Defined: start with num_steps = 0 begins a continuous jog. It ramps and cruises indefinitely; remaining is not decremented and steps_left reads 0. halt sets remaining = max(ramp_cnt,1), enters DECEL and ends normally with done.
- Not defined: num_steps = 0 gives the immediate done described above.

Test Plan:
- All test parameters: MAX_PERIOD=10, MIN_PERIOD=4, ACCEL_DEC=2.
- Reset mid-move -> outputs 0, state IDLE; next start with num_steps=2 gives intervals 10,10 (no second-step decel increase beyond MAX), then done.
- start, num_steps=10, dir_in=1 -> step intervals 10,8,6,4,4,4,4,6,8,10; done one cycle after the 10th pulse; dir=1 and busy=1 throughout.
- num_steps=3 -> intervals 10,8,10, then done; CRUISE never entered.
- num_steps=100, halt after the 5th pulse -> intervals continue 4,6,8; done after 8 total pulses; steps_left=0.
- estop during the 4th interval of num_steps=10 -> no further pulses; aborted single pulse; done stays 0; start pulsed during busy is ignored.
- num_steps=0 -> done next cycle, zero pulses. With JOG_MODE_EN: continuous 4-cycle pulses after the ramp until halt.

Source files
------------

// File: rtl/step_ramp_gen.sv
// Trapezoidal step-pulse generator: accel/cruise/decel period ramp with start/halt/estop.
// Optional JOG_MODE_EN: num_steps = 0 runs a continuous jog until halt.
module step_ramp_gen #(
    parameter int CNT_W      = 16,
    parameter int STEPS_W    = 16,
    parameter int MAX_PERIOD = 1000,
    parameter int MIN_PERIOD = 100,
    parameter int ACCEL_DEC  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir_in,
    input  logic [STEPS_W-1:0] num_steps,
    input  logic               halt,
    input  logic               estop,
    output logic               step_pulse,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [STEPS_W-1:0] steps_left
);

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

    localparam logic [CNT_W-1:0] P_MAX = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] P_DEC = CNT_W'(ACCEL_DEC);

    state_t             state, state_n;
    logic [CNT_W-1:0]   timer, timer_n;
    logic [CNT_W-1:0]   period, period_n;
    logic [STEPS_W-1:0] ramp_cnt, ramp_n;
    logic [STEPS_W-1:0] remaining, rem_n;
    logic               dir_n, pulse_n, done_n, abort_n;
    logic               fin, fin_n;
    logic               jog, jog_n;

    logic [CNT_W:0]     up_sum;
    logic [CNT_W-1:0]   per_up, per_dn;
    logic [STEPS_W-1:0] ramp_inc, ramp_dec, rem_dec, ramp_min1, halt_rem;
    logic               tick;

    always_comb begin
        up_sum    = {1'b0, period} + {1'b0, P_DEC};
        per_up    = (up_sum > {1'b0, P_MAX}) ? P_MAX : up_sum[CNT_W-1:0];
        per_dn    = ({1'b0, period} >= ({1'b0, P_MIN} + {1'b0, P_DEC}))
                    ? period - P_DEC : P_MIN;
        ramp_inc  = (&ramp_cnt) ? ramp_cnt : ramp_cnt + 1'b1;
        ramp_dec  = (ramp_cnt == '0) ? '0 : ramp_cnt - 1'b1;
        rem_dec   = remaining - 1'b1;
        ramp_min1 = (ramp_cnt == '0) ? STEPS_W'(1) : ramp_cnt;
        halt_rem  = (jog || remaining > ramp_min1) ? ramp_min1 : remaining;
        tick      = (state != IDLE) && (timer == period - CNT_W'(1));
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        period_n = period;
        ramp_n   = ramp_cnt;
        rem_n    = remaining;
        dir_n    = dir;
        pulse_n  = 1'b0;
        done_n   = fin;
        abort_n  = 1'b0;
        fin_n    = 1'b0;
        jog_n    = jog;
        unique case (state)
            IDLE: begin
                if (start && !estop) begin
                    if (num_steps != '0) begin
                        dir_n    = dir_in;
                        rem_n    = num_steps;
                        period_n = P_MAX;
                        timer_n  = '0;
                        ramp_n   = '0;
                        state_n  = ACCEL;
                    end else begin
`ifdef JOG_MODE_EN
                        dir_n    = dir_in;
                        rem_n    = '0;
                        jog_n    = 1'b1;
                        period_n = P_MAX;
                        timer_n  = '0;
                        ramp_n   = '0;
                        state_n  = ACCEL;
`else
                        done_n   = 1'b1;
`endif
                    end
                end
            end
            default: begin
                if (estop) begin
                    state_n  = IDLE;
                    abort_n  = 1'b1;
                    timer_n  = '0;
                    period_n = '0;
                    ramp_n   = '0;
                    rem_n    = '0;
                    jog_n    = 1'b0;
                end else if (tick) begin
                    timer_n = '0;
                    pulse_n = 1'b1;
                    if (jog) begin
                        if (state == ACCEL) begin
                            ramp_n   = ramp_inc;
                            period_n = per_dn;
                            if (per_dn == P_MIN) state_n = CRUISE;
                        end
                    end else if (rem_dec == '0) begin
                        state_n  = IDLE;
                        fin_n    = 1'b1;
                        period_n = '0;
                        ramp_n   = '0;
                        rem_n    = '0;
                    end else begin
                        rem_n = rem_dec;
                        // Decelerate once the steps left fit inside the ramp built so far.
                        unique case (state)
                            ACCEL: begin
                                ramp_n = ramp_inc;
                                if (rem_dec <= ramp_inc) begin
                                    state_n  = DECEL;
                                    period_n = per_up;
                                end else begin
                                    period_n = per_dn;
                                    if (per_dn == P_MIN) state_n = CRUISE;
                                end
                            end
                            CRUISE: begin
                                if (rem_dec <= ramp_cnt) begin
                                    state_n  = DECEL;
                                    period_n = per_up;
                                end
                            end
                            default: begin
                                period_n = per_up;
                                ramp_n   = ramp_dec;
                            end
                        endcase
                    end
                end else begin
                    timer_n = timer + 1'b1;
                    if (halt && state != DECEL) begin
                        rem_n   = halt_rem;
                        jog_n   = 1'b0;
                        state_n = DECEL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            period     <= '0;
            ramp_cnt   <= '0;
            remaining  <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            fin        <= 1'b0;
            jog        <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            period     <= period_n;
            ramp_cnt   <= ramp_n;
            remaining  <= rem_n;
            dir        <= dir_n;
            step_pulse <= pulse_n;
            done       <= done_n;
            aborted    <= abort_n;
            fin        <= fin_n;
            jog        <= jog_n;
        end
    end

    assign busy       = (state != IDLE);
    assign steps_left = remaining;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen with MAX_PERIOD=10, MIN_PERIOD=4, ACCEL_DEC=2.
module tb_step_ramp_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        dir_in = 1'b0;
    logic [15:0] num_steps = '0;
    logic        halt = 1'b0;
    logic        estop = 1'b0;
    logic        step_pulse, dir, busy, done, aborted;
    logic [15:0] steps_left;

    int total = 0;
    int fails = 0;

    step_ramp_gen #(
        .CNT_W(16), .STEPS_W(16),
        .MAX_PERIOD(10), .MIN_PERIOD(4), .ACCEL_DEC(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .dir_in(dir_in),
        .num_steps(num_steps), .halt(halt), .estop(estop),
        .step_pulse(step_pulse), .dir(dir), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedges until step_pulse is seen; -1 on timeout.
    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic go(input int ns, input logic d);
        start     = 1'b1;
        num_steps = 16'(ns);
        dir_in    = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done_lo"}, 32'(done), 0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_idle"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 0);
    endtask

    task automatic run_iv(input string tag, input int exp[$]);
        int n;
        foreach (exp[i]) begin
            wait_pulse(n);
            chk($sformatf("%s_iv%0d", tag, i + 1), 32'(n), 32'(exp[i]));
        end
    endtask

    initial begin
        int n;
        int bad;
        int cnt_p;
        int cnt_d;
        int iv10[$] = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};

        repeat (2) @(negedge clk);
        chk("rst_pulse", 32'(step_pulse), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_abort", 32'(aborted), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_left", 32'(steps_left), 0);
        reset = 1'b1;
        @(negedge clk);

        // Full trapezoid, 10 steps
        go(10, 1'b1);
        chk("t10_busy", 32'(busy), 1);
        chk("t10_left", 32'(steps_left), 10);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            wait_pulse(n);
            chk($sformatf("t10_iv%0d", i + 1), 32'(n), 32'(iv10[i]));
            if (i < 9 && (busy !== 1'b1 || dir !== 1'b1)) bad++;
        end
        chk("t10_busy_dir", 32'(bad), 0);
        expect_done("t10");

        // Short move never reaches cruise
        go(3, 1'b0);
        chk("t3_dir", 32'(dir), 0);
        run_iv("t3", '{10, 8, 10});
        expect_done("t3");

        // Halt during cruise
        go(100, 1'b1);
        run_iv("th", '{10, 8, 6, 4, 4});
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("th_left", 32'(steps_left), 3);
        wait_pulse(n);
        chk("th_iv6", 32'(n + 1), 4);
        run_iv("th_tail", '{6, 8});
        chk("th_left_end", 32'(steps_left), 0);
        expect_done("th");

        // Start while busy ignored, then estop in the 4th interval
        go(10, 1'b1);
        wait_pulse(n);
        chk("te_iv1", 32'(n), 10);
        start     = 1'b1;
        num_steps = 16'd1;
        dir_in    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_pulse(n);
        chk("te_iv2", 32'(n + 1), 8);
        chk("te_dir", 32'(dir), 1);
        wait_pulse(n);
        chk("te_iv3", 32'(n), 6);
        repeat (2) @(negedge clk);
        estop = 1'b1;
        @(negedge clk);
        chk("te_abort", 32'(aborted), 1);
        chk("te_idle", 32'(busy), 0);
        estop = 1'b0;
        @(negedge clk);
        chk("te_abort_1cyc", 32'(aborted), 0);
        cnt_p = 0;
        cnt_d = 0;
        repeat (30) begin
            @(negedge clk);
            if (step_pulse === 1'b1) cnt_p++;
            if (done === 1'b1) cnt_d++;
        end
        chk("te_no_pulse", 32'(cnt_p), 0);
        chk("te_no_done", 32'(cnt_d), 0);

        // Reset mid-move
        go(10, 1'b1);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("tr_busy", 32'(busy), 0);
        chk("tr_dir", 32'(dir), 0);
        chk("tr_left", 32'(steps_left), 0);
        chk("tr_flags", 32'({step_pulse, done, aborted}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("tr_no_done", 32'({done, aborted}), 0);
        go(2, 1'b1);
        run_iv("tr2", '{10, 10});
        expect_done("tr2");

`ifdef JOG_MODE_EN
        go(0, 1'b1);
        chk("tj_busy", 32'(busy), 1);
        run_iv("tj", '{10, 8, 6, 4, 4, 4});
        chk("tj_left", 32'(steps_left), 0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        wait_pulse(n);
        chk("tj_iv7", 32'(n + 1), 4);
        run_iv("tj_tail", '{6, 8});
        expect_done("tj");
`else
        go(0, 1'b1);
        chk("tz_done", 32'(done), 1);
        chk("tz_busy", 32'(busy), 0);
        cnt_p = 0;
        cnt_d = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_pulse === 1'b1) cnt_p++;
            if (done === 1'b1) cnt_d++;
        end
        chk("tz_no_pulse", 32'(cnt_p), 0);
        chk("tz_done_once", 32'(cnt_d), 0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
